// File: rtl/xpt_phase_sequencer.sv
// Instruction phase sequencer: fetches opcodes, steps the XPT phase timer,
// and runs decoder-requested memory read/write cycles with a bus timeout.
module xpt_phase_sequencer #(
    parameter int unsigned WAIT_MAX     = 15,
    parameter logic [7:0]  ITABLE_RESET = 8'h00
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PR_Reset_XPT,
    input  logic       P2_Set_CM1,
    input  logic       P2_Reset_ITABLE,
    input  logic       PC_R0,
    input  logic       PC_R1,
    input  logic       PC_R2,
    input  logic       PC_W0,
    input  logic       PC_W1,
    input  logic       PC_W2,
    input  logic       mem_ready,
    input  logic [7:0] mem_rdata,
    output logic       enable,
    output logic [3:0] XPT,
    output logic [3:0] notXPT,
    output logic [7:0] ITABLE,
    output logic [7:0] notITABLE,
    output logic       CM1,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ad_sel_pc,
    output logic       pc_inc,
    output logic [7:0] dt_latch,
    output logic       err_seq,
    output logic       err_bus
);

    localparam int unsigned XPT_W  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WCNT_W = 8;
    localparam logic [XPT_W-1:0]  XPT_LAST  = XPT_W'(15);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXEC    = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_e;

    state_e              state_q,     state_d;
    logic [XPT_W-1:0]    xpt_q,       xpt_d;
    logic [DATA_W-1:0]   itable_q,    itable_d;
    logic                cm1_q,       cm1_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic                ad_sel_pc_q, ad_sel_pc_d;
    logic                pc_inc_q,    pc_inc_d;
    logic [DATA_W-1:0]   dt_latch_q,  dt_latch_d;
    logic                err_seq_q,   err_seq_d;
    logic                err_bus_q,   err_bus_d;
    logic [WCNT_W-1:0]   wait_cnt_q,  wait_cnt_d;
    logic                pend_pr_q,   pend_pr_d;
    logic                pend_cm1_q,  pend_cm1_d;
    logic                pend_rit_q,  pend_rit_d;

    logic rd_any_c;
    logic wr_any_c;
    logic do_end_c;
    logic end_cm1_c;
    logic end_rit_c;
    logic do_step_c;

    assign rd_any_c = PC_R0 | PC_R1 | PC_R2;
    assign wr_any_c = PC_W0 | PC_W1 | PC_W2;

    // State register and all registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_FETCH;
            xpt_q       <= '0;
            itable_q    <= ITABLE_RESET;
            cm1_q       <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            ad_sel_pc_q <= 1'b0;
            pc_inc_q    <= 1'b0;
            dt_latch_q  <= '0;
            err_seq_q   <= 1'b0;
            err_bus_q   <= 1'b0;
            wait_cnt_q  <= '0;
            pend_pr_q   <= 1'b0;
            pend_cm1_q  <= 1'b0;
            pend_rit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            xpt_q       <= xpt_d;
            itable_q    <= itable_d;
            cm1_q       <= cm1_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            ad_sel_pc_q <= ad_sel_pc_d;
            pc_inc_q    <= pc_inc_d;
            dt_latch_q  <= dt_latch_d;
            err_seq_q   <= err_seq_d;
            err_bus_q   <= err_bus_d;
            wait_cnt_q  <= wait_cnt_d;
            pend_pr_q   <= pend_pr_d;
            pend_cm1_q  <= pend_cm1_d;
            pend_rit_q  <= pend_rit_d;
        end
    end

    // Next-state logic: per-state decisions, then shared end-of-phase / step actions
    always_comb begin
        state_d     = state_q;
        xpt_d       = xpt_q;
        itable_d    = itable_q;
        cm1_d       = cm1_q;
        mem_we_d    = mem_we_q;
        pc_inc_d    = 1'b0;
        dt_latch_d  = dt_latch_q;
        err_seq_d   = err_seq_q;
        err_bus_d   = err_bus_q;
        wait_cnt_d  = wait_cnt_q;
        pend_pr_d   = pend_pr_q;
        pend_cm1_d  = pend_cm1_q;
        pend_rit_d  = pend_rit_q;
        do_end_c    = 1'b0;
        end_cm1_c   = 1'b0;
        end_rit_c   = 1'b0;
        do_step_c   = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                // Opcode accepted only once the request is actually on the bus
                if (mem_req_q && mem_ready) begin
                    itable_d = mem_rdata;
                    cm1_d    = 1'b0;
                    xpt_d    = '0;
                    pc_inc_d = 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (rd_any_c || wr_any_c) begin
                    state_d    = ST_MEMWAIT;
                    wait_cnt_d = '0;
                    mem_we_d   = wr_any_c;
                    if (rd_any_c && wr_any_c) begin
                        err_seq_d = 1'b1;
                    end
                    pend_pr_d  = PR_Reset_XPT;
                    pend_cm1_d = P2_Set_CM1;
                    pend_rit_d = P2_Reset_ITABLE;
                end else if (PR_Reset_XPT) begin
                    do_end_c  = 1'b1;
                    end_cm1_c = P2_Set_CM1;
                    end_rit_c = P2_Reset_ITABLE;
                end else begin
                    do_step_c = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                if (mem_ready) begin
                    if (!mem_we_q) begin
                        dt_latch_d = mem_rdata;
                    end
                    mem_we_d   = 1'b0;
                    pend_pr_d  = 1'b0;
                    pend_cm1_d = 1'b0;
                    pend_rit_d = 1'b0;
                    if (pend_pr_q) begin
                        do_end_c  = 1'b1;
                        end_cm1_c = pend_cm1_q;
                        end_rit_c = pend_rit_q;
                    end else begin
                        do_step_c = 1'b1;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_bus_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    xpt_d      = '0;
                    cm1_d      = 1'b1;
                    itable_d   = ITABLE_RESET;
                    pend_pr_d  = 1'b0;
                    pend_cm1_d = 1'b0;
                    pend_rit_d = 1'b0;
                    state_d    = ST_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // End of phase sequence: restart timer, optionally clear opcode / refetch
        if (do_end_c) begin
            xpt_d = '0;
            if (end_rit_c) begin
                itable_d = ITABLE_RESET;
            end
            if (end_cm1_c) begin
                cm1_d   = 1'b1;
                state_d = ST_FETCH;
            end else begin
                state_d = ST_EXEC;
            end
        end

        // Phase advance; the timer never wraps, running off the end is an error
        if (do_step_c) begin
            if (xpt_q == XPT_LAST) begin
                err_seq_d = 1'b1;
                xpt_d     = '0;
                itable_d  = ITABLE_RESET;
                cm1_d     = 1'b1;
                state_d   = ST_FETCH;
            end else begin
                xpt_d   = xpt_q + XPT_W'(1);
                state_d = ST_EXEC;
            end
        end

        // Bus request drops for one cycle whenever FETCH is (re)entered
        mem_req_d   = (state_d == ST_MEMWAIT) ||
                      ((state_q == ST_FETCH) && (state_d == ST_FETCH));
        ad_sel_pc_d = (state_d == ST_FETCH);
    end

    assign enable    = (state_q == ST_EXEC);
    assign XPT       = xpt_q;
    assign notXPT    = ~xpt_q;
    assign ITABLE    = itable_q;
    assign notITABLE = ~itable_q;
    assign CM1       = cm1_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign ad_sel_pc = ad_sel_pc_q;
    assign pc_inc    = pc_inc_q;
    assign dt_latch  = dt_latch_q;
    assign err_seq   = err_seq_q;
    assign err_bus   = err_bus_q;

endmodule

// File: doc/xpt_phase_sequencer.md
Name: xpt_phase_sequencer

Overview:
- Drives the instruction-decoder tree and sequences each instruction through its execution phases.
- Fetches the opcode and latches it into ITABLE/notITABLE.
- Steps the 4-bit phase timer XPT/notXPT and runs memory read/write bus cycles requested by the decoder strobes (PC_R*/PC_W*).
- Applies the decoder's end-of-instruction controls: PR_Reset_XPT, P2_Set_CM1, P2_Reset_ITABLE.
- Sits between the top-level decoder (enable input) and the memory bus interface.

Parameters:
- WAIT_MAX, 15, maximum cycles to wait for mem_ready before a bus-timeout abort (1..255).
- ITABLE_RESET, 8'h00, value loaded into ITABLE on reset and on P2_Reset_ITABLE (the NOP opcode).

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  synchronous active-high reset.
- PR_Reset_XPT  in  1  decoder: end phase sequence.
- P2_Set_CM1  in  1  decoder: return to opcode fetch (M1).
- P2_Reset_ITABLE  in  1  decoder: clear opcode register.
- PC_R0 / PC_R1 / PC_R2  in  1 each  decoder: read-cycle strobes.
- PC_W0 / PC_W1 / PC_W2  in  1 each  decoder: write-cycle strobes.
- mem_ready  in  1  bus: transfer complete this cycle.
- mem_rdata  in  8  bus read data, valid when mem_ready=1.
- enable  out  1  decoder-tree enable.
- XPT  out  4  phase timer.
- notXPT  out  4  bitwise inverse of XPT.
- ITABLE  out  8  current opcode.
- notITABLE  out  8  bitwise inverse of ITABLE.
- CM1  out  1  opcode-fetch cycle flag.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write (1) / read (0).
- ad_sel_pc  out  1  address mux selects PC; 1 only during fetch.
- pc_inc  out  1  one-cycle PC increment pulse.
- dt_latch  out  8  last operand read from the bus.
- err_seq  out  1  sticky: XPT overflow or R/W strobe conflict.
- err_bus  out  1  sticky: bus timeout.

Behaviour:
- States: FETCH, EXEC, MEMWAIT. All outputs are registered except notXPT, notITABLE and enable, which are combinational.
- Reset values:
  - state=FETCH, XPT=0, ITABLE=ITABLE_RESET, CM1=1.
  - mem_req=0, mem_we=0, ad_sel_pc=0, pc_inc=0, dt_latch=0.
  - err_seq=0, err_bus=0, wait counter=0, pending flags=0.
- FETCH:
  - mem_req=1, mem_we=0, ad_sel_pc=1, enable=0.
  - On mem_ready: ITABLE<=mem_rdata, CM1<=0, XPT<=0, pc_inc=1 for 1 cycle, next state EXEC.
- EXEC: enable=1. Decoder inputs are sampled each cycle and resolved in this priority:
  1. Any PC_R*/PC_W* strobe:
     - Enter MEMWAIT; mem_req<=1.
     - mem_we<=1 if any W strobe is high.
     - R and W strobes high together: the write is performed and err_seq<=1.
     - PR_Reset_XPT, P2_Set_CM1 and P2_Reset_ITABLE sampled in the same cycle are stored as pending flags.
     - XPT holds.
  2. PR_Reset_XPT:
     - XPT<=0.
     - If P2_Reset_ITABLE: ITABLE<=ITABLE_RESET.
     - If P2_Set_CM1: CM1<=1 and go to FETCH; otherwise stay in EXEC (prefix continuation).
  3. Otherwise:
     - XPT<=XPT+1.
     - At XPT=15 (no wrap allowed): err_seq<=1, XPT<=0, ITABLE<=ITABLE_RESET, CM1<=1, go to FETCH.
- P2_Set_CM1 or P2_Reset_ITABLE without PR_Reset_XPT: ignored.
- MEMWAIT:
  - enable=0; the wait counter increments each cycle.
  - On mem_ready:
    - mem_req<=0; if it was a read, dt_latch<=mem_rdata.
    - If pending PR_Reset_XPT: apply rule 2 using the pending flags, then clear them.
    - Otherwise XPT<=XPT+1 and return to EXEC.
  - Wait counter reaching WAIT_MAX without mem_ready:
    - err_bus<=1, mem_req<=0.
    - Abort to FETCH with XPT=0, CM1=1, ITABLE=ITABLE_RESET; pending flags cleared.
- Bus latency: mem_req rises on the edge after the decoder strobe. A zero-wait transfer costs 2 cycles of XPT hold.
- RST mid-transfer: all state returns to reset values on that edge; mem_req=0 for one cycle, then FETCH re-requests.
- Error flags clear only on RST.

Test Plan:
- RST, then mem_ready=1 with rdata=8'h1D on the 2nd cycle -> ITABLE=8'h1D, notITABLE=8'hE2, CM1=0, pc_inc single pulse, XPT=0, enable=1.
- EXEC, no strobes for 3 cycles -> XPT 0->1->2->3. PR_Reset_XPT+P2_Set_CM1+P2_Reset_ITABLE -> XPT=0, ITABLE=8'h00, CM1=1, state FETCH, ad_sel_pc=1.
- At XPT=2, PC_W0=1 together with PR_Reset_XPT/P2_Set_CM1 -> mem_req=1, mem_we=1, XPT held at 2. mem_ready after 3 cycles -> XPT=0, CM1=1, FETCH.
- At XPT=1, PC_R0=1, mem_ready with rdata=8'h5A -> dt_latch=8'h5A, XPT=2, mem_we=0 throughout.
- PC_R1 and PC_W1 both high -> write performed, err_seq=1 and sticky. With WAIT_MAX=4 and mem_ready never asserted -> err_bus=1 after 4 cycles, FETCH, ITABLE=8'h00.
- Drive XPT to 15 with no reset strobe -> err_seq=1, FETCH. Assert RST during MEMWAIT -> next cycle all outputs at reset values, errors cleared.
